dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_array.sv | 30 +++
 rtl/dmem_responder.sv | 169 ++++++++++++++++
 tb/tb_dmem_responder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and default sizing for the dmem_responder data-memory slave.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DMEM_N       = 32;
    localparam int DMEM_DEPTH   = 64;
    localparam int DMEM_LATENCY = 2;

    // Width of the WAIT down-counter: it counts LATENCY-2 .. 0, never below one bit.
    function automatic int cnt_width(input int latency);
        return (latency > 2) ? $clog2(latency - 1) : 1;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for dmem_responder: synchronous write, registered read, no reset.
module dmem_array #(
    parameter int n     = 32,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] idx_i,
    input  logic [n-1:0]  wdata_i,
    output logic [n-1:0]  rdata_o
);

    logic [n-1:0] mem_q [DEPTH];
    logic [n-1:0] rdata_q;

    // Single port: at most one of write or read is strobed per cycle.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for a single-cycle/multicycle datapath.
// Optional feature: define DMEM_ALIGN_CHECK_EN to flag misaligned accesses
// (write suppressed, readdata returns 0, err pulses with ready).
//
// Handshake: req is sampled only in IDLE; that edge accepts the request and
// raises busy. Exactly LATENCY cycles later ready pulses for one cycle (the RESP
// state) with readdata/err valid; busy drops on the edge leaving RESP. Inputs
// seen while busy are ignored, so a held req re-issues once back in IDLE.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int n       = DMEM_N,
    parameter int DEPTH   = DMEM_DEPTH,
    parameter int LATENCY = DMEM_LATENCY
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req,
    input  logic         we,
    input  logic [n-1:0] addr,
    input  logic [n-1:0] writedata,
    output logic [n-1:0] readdata,
    output logic         ready,
    output logic         busy,
    output logic         err
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(LATENCY);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY >= 2) ? LATENCY - 2 : 0);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             we_q;
    logic [AW-1:0]    idx_q;
    logic [n-1:0]     wdata_q;
    logic             ready_q;
    logic             busy_q;
    logic             rd_valid_q;
    logic [n-1:0]     rd_data;

    logic             op_we;
    logic [AW-1:0]    op_idx;
    logic [n-1:0]     op_wdata;
    logic             aligned;
    logic             go_resp;
    logic             mem_we;
    logic             mem_re;
    logic             unused_addr;

`ifdef DMEM_ALIGN_CHECK_EN
    logic [1:0]       lo_q;
    logic             err_q;
    assign unused_addr = ^addr[n-1:AW+2];
`else
    assign unused_addr = ^{addr[n-1:AW+2], addr[1:0]};
`endif

    // Operand source: live inputs on the accepting edge (LATENCY=1 commits then), captured copy afterwards.
    always_comb begin
        op_we    = (state_q == IDLE) ? we                 : we_q;
        op_idx   = (state_q == IDLE) ? addr[AW+1:2]       : idx_q;
        op_wdata = (state_q == IDLE) ? writedata          : wdata_q;
`ifdef DMEM_ALIGN_CHECK_EN
        aligned  = ((state_q == IDLE) ? addr[1:0] : lo_q) == 2'b00;
`else
        aligned  = 1'b1;
`endif
        go_resp  = 1'b0;
        if ((state_q == IDLE) && req && (LATENCY == 1)) begin
            go_resp = 1'b1;
        end
        if ((state_q == WAIT) && (cnt_q == '0)) begin
            go_resp = 1'b1;
        end
        mem_we = go_resp && !reset && op_we && aligned;
        mem_re = go_resp && !reset && !op_we && aligned;
    end

    // Control FSM with registered ready/busy/err and the request capture registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            rd_valid_q <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
            lo_q       <= 2'b00;
            err_q      <= 1'b0;
`endif
        end else begin
            ready_q <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        idx_q   <= addr[AW+1:2];
                        wdata_q <= writedata;
`ifdef DMEM_ALIGN_CHECK_EN
                        lo_q    <= addr[1:0];
`endif
                        busy_q  <= 1'b1;
                        if (LATENCY == 1) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
            if (go_resp) begin
                ready_q <= 1'b1;
                if (!op_we) begin
                    rd_valid_q <= aligned;
                end
`ifdef DMEM_ALIGN_CHECK_EN
                err_q <= !aligned;
`endif
            end
        end
    end

    dmem_array #(
        .n     (n),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .idx_i   (op_idx),
        .wdata_i (op_wdata),
        .rdata_o (rd_data)
    );

    // A misaligned load (or reset) masks the array output to zero until the next good load.
    assign readdata = rd_valid_q ? rd_data : '0;
    assign ready    = ready_q;
    assign busy     = busy_q;
`ifdef DMEM_ALIGN_CHECK_EN
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (LATENCY=2 main instance, LATENCY=1 side instance).
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int N   = 32;
    localparam int DEP = 64;
    localparam int LAT = 2;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    typedef struct {
        bit           we;
        logic [N-1:0] addr;
        logic [N-1:0] wdata;
        logic [N-1:0] exp_rdata;
        bit           exp_err;
    } vec_t;

    logic         clk;
    logic         reset;
    logic         req, we;
    logic [N-1:0] addr, wdata, readdata;
    logic         ready, busy, err;
    logic         req1, we1;
    logic [N-1:0] addr1, wdata1, readdata1;
    logic         ready1, busy1, err1;

    logic [N:0]   exp_q[$];
    logic [N:0]   mon_e;
    int           checks;
    int           failures;
    int           ready_cnt;
    bit           saw_wait1;
    vec_t         vecs[14];

    dmem_responder #(.n(N), .DEPTH(DEP), .LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .writedata(wdata),
        .readdata(readdata), .ready(ready), .busy(busy), .err(err)
    );

    dmem_responder #(.n(N), .DEPTH(DEP), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .req(req1), .we(we1), .addr(addr1), .writedata(wdata1),
        .readdata(readdata1), .ready(ready1), .busy(busy1), .err(err1)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every ready pulse of the main DUT pops one expected {err, readdata}.
    always @(negedge clk) begin
        if (!reset && ready) begin
            ready_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_ready", ready, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                check("readdata", readdata, mon_e[N-1:0]);
                check("err", err, mon_e[N]);
            end
        end
    end

    always @(negedge clk) begin
        if (u_dut1.state_q == WAIT) saw_wait1 = 1'b1;
    end

    function automatic vec_t mk(bit w, logic [N-1:0] a, logic [N-1:0] d, logic [N-1:0] r, bit e);
        vec_t v;
        v.we = w; v.addr = a; v.wdata = d; v.exp_rdata = r; v.exp_err = e;
        return v;
    endfunction

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("idle_timeout", busy, 1'b0);
    endtask

    // Issue one request at a negedge, then scramble inputs while busy and time the response.
    task automatic run_op(input vec_t v, input int idx);
        int lat  = 0;
        int bcnt = 0;
        bit seen = 1'b0;
        wait_idle();
        req = 1'b1; we = v.we; addr = v.addr; wdata = v.wdata;
        exp_q.push_back({v.exp_err, v.exp_rdata});
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) begin
                req = 1'b0;
                we = 1'($urandom_range(0, 1));
                addr = $urandom;
                wdata = $urandom;
            end
            if (!seen) begin
                if (busy) bcnt++;
                if (ready) begin
                    seen = 1'b1;
                    lat = i;
                end
            end else begin
                check($sformatf("busy_after_ready[%0d]", idx), busy, 1'b0);
                break;
            end
        end
        check($sformatf("latency[%0d]", idx), lat, LAT);
        check($sformatf("busy_cycles[%0d]", idx), bcnt, LAT);
    endtask

    logic [N-1:0] w2;
    logic [N-1:0] b2b_addr[6];
    int           r0;

    initial begin
        checks = 0; failures = 0; ready_cnt = 0; saw_wait1 = 1'b0;
        reset = 1'b1;
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_readdata", readdata, '0);
        check("rst_ready", ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_ready1", ready1, 1'b0);
        check("rst_busy1", busy1, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Word 2 (0x08) ends up with 0x55 only when misaligned stores are not suppressed.
        w2 = ALIGN ? 32'hABCD1234 : 32'h0000_0055;
        vecs[0]  = mk(1, 32'h010, 32'h0BADF00D, 32'h0,        1'b0);
        vecs[1]  = mk(1, 32'h008, 32'hABCD1234, 32'h0,        1'b0);
        vecs[2]  = mk(0, 32'h008, 32'h0,        32'hABCD1234, 1'b0);
        vecs[3]  = mk(1, 32'h100, 32'h11111111, 32'hABCD1234, 1'b0);
        vecs[4]  = mk(0, 32'h000, 32'h0,        32'h11111111, 1'b0);
        vecs[5]  = mk(1, 32'h00A, 32'h00000055, 32'h11111111, ALIGN);
        vecs[6]  = mk(0, 32'h008, 32'h0,        w2,           1'b0);
        vecs[7]  = mk(1, 32'h3FC, 32'hCAFEF00D, w2,           1'b0);
        vecs[8]  = mk(0, 32'h0FC, 32'h0,        32'hCAFEF00D, 1'b0);
        vecs[9]  = mk(0, 32'h010, 32'h0,        32'h0BADF00D, 1'b0);
        vecs[10] = mk(1, 32'h020, 32'h12345678, 32'h0BADF00D, 1'b0);
        vecs[11] = mk(0, 32'h120, 32'h0,        32'h12345678, 1'b0);
        vecs[12] = mk(0, 32'h00B, 32'h0,        ALIGN ? 32'h0 : 32'h55, ALIGN);
        vecs[13] = mk(0, 32'h008, 32'h0,        w2,           1'b0);
        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i], i);
        end

        // Back-to-back: req held 6 cycles, accepted only at cycles 0 and 3.
        wait_idle();
        b2b_addr[0] = 32'h008; b2b_addr[1] = 32'h0FC; b2b_addr[2] = 32'h020;
        b2b_addr[3] = 32'h100; b2b_addr[4] = 32'h010; b2b_addr[5] = 32'h3FC;
        r0 = ready_cnt;
        exp_q.push_back({1'b0, w2});
        exp_q.push_back({1'b0, 32'h11111111});
        for (int i = 0; i < 6; i++) begin
            req = 1'b1; we = 1'b0; addr = b2b_addr[i]; wdata = $urandom;
            @(negedge clk);
        end
        req = 1'b0;
        repeat (4) @(negedge clk);
        check("b2b_ready_pulses", ready_cnt - r0, 2);

        // Reset in mid-WAIT: the store must not commit.
        wait_idle();
        req = 1'b1; we = 1'b1; addr = 32'h010; wdata = 32'hDEADBEEF;
        @(negedge clk);
        req = 1'b0;
        check("midwait_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        check("midwait_rst_busy", busy, 1'b0);
        check("midwait_rst_readdata", readdata, '0);
        @(negedge clk);
        reset = 1'b0;
        r0 = ready_cnt;
        @(negedge clk);
        check("midwait_no_ready", ready_cnt - r0, 0);
        run_op(mk(0, 32'h010, 32'h0, 32'h0BADF00D, 1'b0), 100);

        // LATENCY=1 instance: ready in the cycle right after acceptance, WAIT never visited.
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h004; wdata1 = 32'h00000077;
        @(negedge clk);
        req1 = 1'b0;
        check("l1_store_ready", ready1, 1'b1);
        check("l1_store_busy", busy1, 1'b1);
        check("l1_store_readdata", readdata1, '0);
        @(negedge clk);
        check("l1_store_ready_pulse", ready1, 1'b0);
        check("l1_store_busy_drop", busy1, 1'b0);
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h004;
        @(negedge clk);
        req1 = 1'b0;
        check("l1_load_ready", ready1, 1'b1);
        check("l1_load_readdata", readdata1, 32'h00000077);
        check("l1_load_err", err1, 1'b0);
        @(negedge clk);
        check("l1_load_ready_pulse", ready1, 1'b0);
        check("l1_no_wait", saw_wait1, 1'b0);

        check("scoreboard_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
